// File: rtl/flash_rd_pkg.sv
// flash_rd_pkg: shared FSM states, SPI opcodes and phase lengths for the XIP flash reader
package flash_rd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_DONE} state_t;
  localparam logic [7:0] CMD_QIO_READ = 8'hEB;
  localparam logic [7:0] MODE_BYTE = 8'hFF;
  localparam int CMD_CLKS = 8;
  localparam int ADDR_CLKS = 6;
  localparam int MODE_CLKS = 2;
  localparam int DUMMY_CLKS = 4;
  function automatic logic [6:0] ph_len(state_t s, int lw);
    return 7'(s == S_CMD ? CMD_CLKS : s == S_ADDR ? ADDR_CLKS : s == S_MODE ? MODE_CLKS :
              s == S_DUMMY ? DUMMY_CLKS : lw * 8);
  endfunction
endpackage

// File: rtl/qspi_shifter.sv
// qspi_shifter: SCK generation, per-phase clock counting and quad I/O shift registers
module qspi_shifter
  import flash_rd_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  state_t                     ph,
  input  logic [23:0]                addr,
  input  logic [3:0]                 din,
  output logic                       sck,
  output logic [3:0]                 dout,
  output logic                       douten,
  output logic [LINE_WORDS*32-1:0]   rx,
  output logic                       ph_end
);
  logic [6:0] cnt, len;
  logic [39:0] sr;
  logic act, stop;
  assign act = ph inside {S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA};
  assign len = ph_len(ph, LINE_WORDS);
  // DATA keeps one extra low-SCK cycle after its last fall as CE hold time
  assign stop = ph == S_DATA && cnt == len;
  assign ph_end = ph == S_DATA ? stop : act && sck && cnt == len - 7'd1;
  assign douten = ph inside {S_CMD, S_ADDR, S_MODE};
  assign dout = ph == S_CMD ? {3'b110, sr[39]} : douten ? sr[39:36] : 4'b1100;
  // opcode, address and mode byte sit back to back so phases never reload
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      sck <= 1'b0;
      cnt <= '0;
      sr <= '0;
      rx <= '0;
    end else if (!act) begin
      sck <= 1'b0;
      cnt <= '0;
      sr <= {CMD_QIO_READ, addr, MODE_BYTE};
    end else if (!stop) begin
      sck <= ~sck;
      if (sck) begin
        cnt <= ph_end ? '0 : cnt + 7'd1;
        sr <= ph == S_CMD ? sr << 1 : sr << 4;
      end else if (ph == S_DATA)
        rx <= {rx[LINE_WORDS*32-5:0], din};
    end
endmodule

// File: rtl/ahb_flash_reader.sv
// ahb_flash_reader: read-only AHB-Lite XIP slave with a one-line buffer filled by quad I/O reads
module ahb_flash_reader
  import flash_rd_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W = 24
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        inv,
  output logic        sck,
  output logic        ce_n,
  input  logic [3:0]  din,
  output logic [3:0]  dout,
  output logic        douten
);
  localparam int OFS = $clog2(LINE_WORDS * 4);
  localparam int LB = LINE_WORDS * 32;
  state_t state;
  logic sel_q, write_q, trans_q, valid, inv_p, ph_end, rd, hit, unused;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-OFS-1:0] tag;
  logic [LB-1:0] rx;
  logic [LINE_WORDS-1:0][31:0] line, rx_le;
  logic [23:0] fa;
  assign unused = ^{HWDATA, HSIZE, HTRANS[0], HADDR[31:ADDR_W], addr_q[1:0]};
  assign rd = sel_q & ~write_q & trans_q;
  assign hit = valid && tag == addr_q[ADDR_W-1:OFS];
  assign HREADYOUT = state == S_IDLE ? !(rd && !hit) : state == S_DONE;
  assign HRDATA = line[addr_q[OFS-1:2]];
  assign ce_n = !(state inside {S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA});
  assign fa = 24'({addr_q[ADDR_W-1:OFS], {OFS{1'b0}}});
  // the first byte received is the lowest address, so it lands in byte lane 0
  for (genvar b = 0; b < LINE_WORDS * 4; b++) begin : g_le
    assign rx_le[b/4][8*(b%4) +: 8] = rx[LB-1-8*b -: 8];
  end
  qspi_shifter #(.LINE_WORDS(LINE_WORDS)) u_shift (
    .HCLK(HCLK), .HRESETn(HRESETn), .ph(state), .addr(fa), .din(din),
    .sck(sck), .dout(dout), .douten(douten), .rx(rx), .ph_end(ph_end)
  );
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= S_IDLE;
      sel_q <= 1'b0;
      write_q <= 1'b0;
      trans_q <= 1'b0;
      addr_q <= '0;
      valid <= 1'b0;
      inv_p <= 1'b0;
      tag <= '0;
      line <= '0;
    end else begin
      if (HREADY) begin
        sel_q <= HSEL;
        write_q <= HWRITE;
        trans_q <= HTRANS[1];
        addr_q <= HADDR[ADDR_W-1:0];
      end
      case (state)
        S_IDLE: begin
          if (inv) valid <= 1'b0;
          if (rd && !hit) begin
            state <= S_CMD;
            inv_p <= 1'b0;
          end
        end
        S_DONE: begin
          valid <= !(inv_p || inv);
          tag <= addr_q[ADDR_W-1:OFS];
          state <= S_IDLE;
        end
        default: begin
          inv_p <= inv_p | inv;
          if (ph_end) state <= state_t'(state + 3'd1);
          if (ph_end && state == S_DATA) line <= rx_le;
        end
      endcase
    end
endmodule

// File: tb/tb_ahb_flash_reader.sv
// tb_ahb_flash_reader: directed AHB reads against a behavioural quad-SPI flash model
module tb_ahb_flash_reader;
  logic HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0, inv = 1'b0;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0] HTRANS = '0;
  logic [2:0] HSIZE = 3'd2;
  logic HREADY, HREADYOUT, sck, ce_n, douten;
  logic [31:0] HRDATA;
  logic [3:0] din = '0, dout;
  int n_chk = 0, n_err = 0, nb = 0, k = 0, w = 0, nb0 = 0;
  logic [7:0] cmd_s = '0, mode_s = '0;
  logic [23:0] addr_s = '0;
  logic oe_bad = 1'b0;
  logic [31:0] d;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb_flash_reader dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HSIZE(HSIZE),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .inv(inv), .sck(sck), .ce_n(ce_n),
    .din(din), .dout(dout), .douten(douten)
  );

  // flash content: byte at address a is a[7:0] + 0x11
  function automatic logic [3:0] fnib(input logic [23:0] a, input int j);
    logic [7:0] b;
    b = a[7:0] + 8'(j / 2) + 8'h11;
    return j[0] ? b[3:0] : b[7:4];
  endfunction

  always @(negedge ce_n) nb++;

  always @(posedge sck or posedge ce_n)
    if (ce_n) k <= 0;
    else begin
      k <= k + 1;
      if (k < 8) cmd_s <= {cmd_s[6:0], dout[0]};
      else if (k < 14) addr_s <= {addr_s[19:0], dout};
      else if (k < 16) mode_s <= {mode_s[3:0], dout};
      if ((k < 16) != douten) oe_bad <= 1'b1;
      if (k >= 19) din <= fnib(addr_s, k - 19);
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ahb_rd(input logic [31:0] a, output logic [31:0] rdata, output int waits);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    waits = 0;
    while (!HREADYOUT && waits < 300) begin
      @(posedge HCLK); #1;
      waits++;
    end
    rdata = HRDATA;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input int exp_w, input logic [31:0] exp_d);
    ahb_rd(a, d, w);
    check({tag, "_wait"}, 32'(w), 32'(exp_w));
    check({tag, "_data"}, d, exp_d);
  endtask

  initial begin
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_ce_n", 32'(ce_n), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_dout", 32'(dout), 32'hC);
    check("rst_douten", 32'(douten), 32'd0);
    HRESETn = 1'b1;
    rd_chk("cold", 32'h104, 106, 32'h18171615);
    check("cold_cmd", 32'(cmd_s), 32'hEB);
    check("cold_addr", 32'(addr_s), 32'h000100);
    check("cold_mode", 32'(mode_s), 32'hFF);
    check("cold_bursts", 32'(nb), 32'd1);
    rd_chk("hit100", 32'h100, 0, 32'h14131211);
    rd_chk("hit108", 32'h108, 0, 32'h1C1B1A19);
    rd_chk("hit10c", 32'h10C, 0, 32'h201F1E1D);
    check("hit_bursts", 32'(nb), 32'd1);
    rd_chk("cross", 32'h110, 106, 32'h24232221);
    check("cross_addr", 32'(addr_s), 32'h000110);
    rd_chk("hit114", 32'h114, 0, 32'h28272625);
    rd_chk("back100", 32'h100, 106, 32'h14131211);
    check("cross_bursts", 32'(nb), 32'd3);
    fork
      rd_chk("invfill", 32'h120, 106, 32'h34333231);
      begin
        repeat (70) @(posedge HCLK);
        #1 inv = 1'b1;
        @(posedge HCLK);
        #1 inv = 1'b0;
      end
    join
    rd_chk("refetch", 32'h124, 106, 32'h38373635);
    rd_chk("hit128", 32'h128, 0, 32'h3C3B3A39);
    check("inv_bursts", 32'(nb), 32'd5);
    @(posedge HCLK); #1 inv = 1'b1;
    @(posedge HCLK); #1 inv = 1'b0;
    rd_chk("idleinv", 32'h12C, 106, 32'h403F3E3D);
    nb0 = nb;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HADDR = 32'h100; HTRANS = 2'b10; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hDEADBEEF;
    check("wr_hreadyout", 32'(HREADYOUT), 32'd1);
    repeat (3) @(posedge HCLK);
    #1;
    check("wr_ce_n", 32'(ce_n), 32'd1);
    check("wr_bursts", 32'(nb), 32'(nb0));
    @(posedge HCLK); #1;
    HSEL = 1'b1; HADDR = 32'h100; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (51) @(posedge HCLK);
    #1;
    check("mid_ce_n", 32'(ce_n), 32'd0);
    HRESETn = 1'b0;
    #1;
    check("arst_ce_n", 32'(ce_n), 32'd1);
    check("arst_sck", 32'(sck), 32'd0);
    check("arst_douten", 32'(douten), 32'd0);
    check("arst_hreadyout", 32'(HREADYOUT), 32'd1);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    rd_chk("post_rst", 32'h100, 106, 32'h14131211);
    check("rst_bursts", 32'(nb), 32'(nb0 + 2));
    check("douten_phases", 32'(oe_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
